// File: rtl/mod_updown_counter_if.sv
// Control/status bundle of the up/down modulus counter.
// The controller drives the requests (master); the counter answers with its
// count and flags (slave).
interface mod_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             clean;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             co;
  logic             zero;
  logic             ovf;

  modport master (
    output clean, load, load_val, en, up,
    input  count, tc, co, zero, ovf
  );

  modport slave (
    input  clean, load, load_val, en, up,
    output count, tc, co, zero, ovf
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulus counter with parallel load, wrap or saturate
// at the bounds, a combinational terminal-count predictor, a registered
// carry/borrow pulse and a sticky overflow flag. Cascade by driving the next
// stage's en from this stage's tc.
module mod_updown_counter #(
  parameter int          WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 9,
  parameter int          SATURATE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_updown_counter_if.slave  bus
);

  // Reject parameter combinations that would let the count leave 0..MAX_VAL.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 2..32");
  end
  if (MAX_VAL == 0 || 64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("mod_updown_counter: MAX_VAL must be in 1..2^WIDTH-1");
  end
  if (SATURATE != 0 && SATURATE != 1) begin : g_bad_sat
    $error("mod_updown_counter: SATURATE must be 0 or 1");
  end

  // Bounds and step kept one bit wider so that the step past MAX_VAL or
  // below 0 is visible even when MAX_VAL is the natural all-ones value.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_CNT = MAX_EXT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO    = '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic             cross_up;
  logic             cross_dn;
  logic             at_max;
  logic             at_zero;

  assign cnt_ext  = {1'b0, count_q};
  assign inc_ext  = cnt_ext + ONE_EXT;
  assign dec_ext  = cnt_ext - ONE_EXT;
  // An increment past MAX_VAL, or a borrow out of the extra bit, is a bound hit.
  assign cross_up = (inc_ext > MAX_EXT);
  assign cross_dn = dec_ext[WIDTH];
  assign at_max   = (count_q == MAX_CNT);
  assign at_zero  = (count_q == ZERO);

  // Next-state selection: clean beats load beats count enable.
  always_comb begin
    count_d = count_q;
    co_d    = 1'b0;
    ovf_d   = ovf_q;
    if (bus.clean) begin
      count_d = ZERO;
      ovf_d   = 1'b0;
    end else if (bus.load) begin
      if ({1'b0, bus.load_val} > MAX_EXT) begin
        count_d = MAX_CNT;
      end else begin
        count_d = bus.load_val;
      end
    end else if (bus.en) begin
      if (bus.up) begin
        if (cross_up) begin
          co_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = (SATURATE != 0) ? MAX_CNT : ZERO;
        end else begin
          count_d = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (cross_dn) begin
          co_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = (SATURATE != 0) ? ZERO : MAX_CNT;
        end else begin
          count_d = dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= ZERO;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs: tc predicts next cycle's co from the current direction and bound.
  always_comb begin
    bus.count = count_q;
    bus.co    = co_q;
    bus.ovf   = ovf_q;
    bus.zero  = at_zero;
    bus.tc    = bus.en & ((bus.up & at_max) | (~bus.up & at_zero));
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised successor to the team's fixed 3-bit enable/clean counter.
- Configurable width and modulus, up/down direction, parallel load, wrap or saturate mode.
- Provides a combinational terminal-count flag, a registered carry/borrow pulse and a sticky overflow flag.
- Used as a loop/index counter in datapath controllers; instances cascade by feeding `tc` into the next stage's `en`.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..32).
- MAX_VAL, 9, highest count value (legal range 1..2^WIDTH-1). The count cycles over 0..MAX_VAL.
- SATURATE, 0, 0 = wrap at the bounds; 1 = hold at the bounds.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clean  input  1  synchronous clear: count to 0, clears `ovf`.
- load  input  1  synchronous parallel load of `load_val`.
- load_val  input  WIDTH  value to load.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement. Sampled only when `en` is high.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational. It is high when `en` is high and the count sits at the bound for the current direction: `count==MAX_VAL` with `up`=1, or `count==0` with `up`=0.
- co  output  1  registered one-cycle carry/borrow pulse.
- zero  output  1  combinational, `count==0`.
- ovf  output  1  sticky flag, registered; set on any bound crossing or bound hit.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. While `rst` is high, `count`=0, `co`=0, `ovf`=0. Consequently `zero`=1, and `tc`=1 only if `en`=1 and `up`=0.
- Priority per rising edge is `clean` > `load` > `en`. Only one action is taken per cycle.
- clean:
  - `count`<=0, `ovf`<=0, `co`<=0.
  - `load` and `en` are ignored that cycle.
- load:
  - `count`<=`load_val` if `load_val`<=MAX_VAL, otherwise `count`<=MAX_VAL (clamped).
  - `co`<=0. `ovf` is unchanged.
- en, up=1:
  - If `count`<MAX_VAL, then `count`+1.
  - At MAX_VAL with SATURATE=0: `count`<=0, `co`<=1, `ovf`<=1.
  - At MAX_VAL with SATURATE=1: `count` holds MAX_VAL, `co`<=1, `ovf`<=1.
- en, up=0:
  - If `count`>0, then `count`-1.
  - At 0 with SATURATE=0: `count`<=MAX_VAL, `co`<=1, `ovf`<=1.
  - At 0 with SATURATE=1: `count` holds 0, `co`<=1, `ovf`<=1.
- `co` is high for exactly one cycle after each boundary event; otherwise it is 0. In saturate mode with `en` held at the bound, `co` stays high every cycle, one pulse per attempted step.
- `tc` is the pre-edge predictor of the boundary event. Latency: `tc` in cycle N implies `co` in cycle N+1.
- `en`=0 with no `clean` or `load`: everything holds and `co`<=0.
- Direction change mid-count takes effect on the next enabled edge. There is no pipeline.
- Arithmetic is done in WIDTH+1 bits internally. The count never leaves 0..MAX_VAL, including when MAX_VAL = 2^WIDTH-1 (natural overflow case).
- Reset asserted mid-count clears immediately, without waiting for a clock. Counting resumes on the first rising edge after deassertion.
- Out-of-range state is unreachable. Elaboration must error on illegal parameters.

Test Plan:
- Reset/idle (WIDTH=4, MAX_VAL=9): assert `rst` mid-count at 6 → `count`=0, `zero`=1, `co`=0, `ovf`=0 asynchronously; hold `en`=0 for 5 cycles → `count` stays 0.
- Wrap up (SATURATE=0): `en`=1, `up`=1 from 0 for 12 cycles → `count` goes 0..9,0,1,2; `tc`=1 only while `count`=9; `co` high exactly the cycle `count`=0 after 9; `ovf`=1 from then on.
- Wrap down / direction switch: load 2, `up`=0 for 4 edges → 1,0,9,8 with one `co` pulse; then `up`=1 → 9, and `tc` asserts.
- Saturate (SATURATE=1, MAX_VAL=9): count up from 7 for 5 edges → 8,9,9,9,9; `co` high for 3 consecutive cycles; down from 0 → holds 0 with `co`=1.
- Load/clamp/priority: `load_val`=13 → `count`=9; `load`+`en` together with `load_val`=4 → 4 (no increment); `clean`+`load`+`en` → 0 and `ovf` cleared.
- Full-range width (WIDTH=3, MAX_VAL=7, SATURATE=0): 8 enabled edges from 0 → 1..7,0 with a single `co` pulse; behaviour matches the legacy 3-bit counter.
